// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - bit-serial Huffman decoder with loadable 64-entry code table
module huffman_decoder #(
    parameter int NUM_SYM = 64,
    parameter int SYM_W   = 6,
    parameter int CODE_W  = 8,
    parameter int LEN_W   = 4
) (
    input  logic                    i_clock,
    input  logic                    i_resetn,
    input  logic                    i_tbl_we,
    input  logic [SYM_W-1:0]        i_tbl_addr,
    input  logic [CODE_W+LEN_W-1:0] i_tbl_data,
    input  logic [31:0]             i_word_in,
    input  logic                    i_word_valid,
    input  logic                    i_word_last,
    input  logic [5:0]              i_word_bits,
    output logic                    o_word_ready,
    output logic [SYM_W-1:0]        o_sym_out,
    output logic                    o_sym_valid,
    output logic                    o_sym_err,
    output logic                    o_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]               r_state;
    logic [CODE_W+LEN_W-1:0]  r_tbl [NUM_SYM];
    logic [31:0]              r_shreg;
    logic [5:0]               r_limit;
    logic [5:0]               r_cnt;
    logic                     r_last;
    logic [CODE_W-1:0]        r_acc;
    logic [LEN_W-1:0]         r_acc_len;
    logic                     r_word_ready;
    logic [SYM_W-1:0]         r_sym_out;
    logic                     r_sym_valid;
    logic                     r_sym_err;
    logic                     r_done;

    logic                     w_bit;
    logic [CODE_W-1:0]        w_acc_next;
    logic [LEN_W-1:0]         w_len_next;
    logic [LEN_W-1:0]         w_shamt;
    logic [CODE_W-1:0]        w_mask;
    logic [5:0]               w_cnt_next;
    logic                     w_last_bit;
    logic                     w_full;
    logic                     w_hit;
    logic [SYM_W-1:0]         w_hit_idx;

    // Table has no reset so firmware contents survive a link reset
    always_ff @(posedge i_clock) begin
        if (i_tbl_we && r_state == ST_IDLE) begin
            r_tbl[i_tbl_addr] <= i_tbl_data;
        end
    end

    assign w_bit      = r_shreg[31];
    assign w_acc_next = {r_acc[CODE_W-2:0], w_bit};
    assign w_len_next = r_acc_len + 1'b1;
    assign w_shamt    = LEN_W'(CODE_W) - w_len_next;
    assign w_mask     = {CODE_W{1'b1}} >> w_shamt;
    assign w_cnt_next = r_cnt + 6'd1;
    assign w_last_bit = (w_cnt_next == r_limit);
    assign w_full     = (w_len_next == LEN_W'(CODE_W));

    // Scan downwards so the lowest matching index wins on duplicate codes
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (r_tbl[i][LEN_W-1:0] == w_len_next &&
                ((r_tbl[i][CODE_W+LEN_W-1:LEN_W] ^ w_acc_next) & w_mask) == '0) begin
                w_hit     = 1'b1;
                w_hit_idx = SYM_W'(i);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_limit      <= '0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_acc        <= '0;
            r_acc_len    <= '0;
            r_word_ready <= 1'b1;
            r_sym_out    <= '0;
            r_sym_valid  <= 1'b0;
            r_sym_err    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            r_sym_err   <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_word_valid && r_word_ready) begin
                        r_shreg      <= i_word_in;
                        r_limit      <= (i_word_last && i_word_bits != 6'd0) ? i_word_bits : 6'd32;
                        r_last       <= i_word_last;
                        r_cnt        <= '0;
                        r_state      <= ST_BUSY;
                        r_word_ready <= 1'b0;
                    end
                end
                default: begin
                    r_shreg <= {r_shreg[30:0], 1'b0};
                    r_cnt   <= w_cnt_next;
                    if (w_hit) begin
                        r_sym_out   <= w_hit_idx;
                        r_sym_valid <= 1'b1;
                        r_acc       <= '0;
                        r_acc_len   <= '0;
                    end else if (w_full) begin
                        r_sym_err <= 1'b1;
                        r_acc     <= '0;
                        r_acc_len <= '0;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_acc_len <= w_len_next;
                    end
                    // Partial code left at end of stream is padding: drop it silently
                    if (w_last_bit) begin
                        r_state      <= ST_IDLE;
                        r_word_ready <= 1'b1;
                        if (r_last) begin
                            r_done    <= 1'b1;
                            r_acc     <= '0;
                            r_acc_len <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_word_ready = r_word_ready;
    assign o_sym_out    = r_sym_out;
    assign o_sym_valid  = r_sym_valid;
    assign o_sym_err    = r_sym_err;
    assign o_done       = r_done;

endmodule
